// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port between ALU (A) and load (B) writeback.
// Clears every register after reset, then arbitrates round-robin on contention.
module rf_write_arbiter #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_wdata,
    output logic          busy,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        state, next_state;
    grant_t        last_grant;
    logic [AW-1:0] idx;
    logic          contend;
    wr_t           wr_next;

    assign contend = (state == RUN) && a_valid && b_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= next_state;
    end

    // Ready is combinational so a granted request transfers on the very next edge.
    always_comb begin
        next_state = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            INIT: if (idx == LAST_IDX) next_state = RUN;
            RUN: begin
                if (contend) begin
                    if (last_grant == GRANT_B) a_ready = 1'b1;
                    else                       b_ready = 1'b1;
                end else begin
                    a_ready = a_valid;
                    b_ready = b_valid;
                end
            end
            default: next_state = INIT;
        endcase
    end

    // Next write-port contents; rd/data hold when nothing is written.
    always_comb begin
        wr_next.we   = 1'b0;
        wr_next.rd   = rf_rd;
        wr_next.data = rf_wdata;
        if (state == INIT) begin
            wr_next.we   = 1'b1;
            wr_next.rd   = idx;
            wr_next.data = '0;
        end else if (a_ready) begin
            wr_next.we   = 1'b1;
            wr_next.rd   = a_rd;
            wr_next.data = a_data;
        end else if (b_ready) begin
            wr_next.we   = 1'b1;
            wr_next.rd   = b_rd;
            wr_next.data = b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_wdata     <= '0;
            busy         <= 1'b1;
            conflict_cnt <= '0;
            last_grant   <= GRANT_B;
            idx          <= '0;
        end else begin
            rf_we    <= wr_next.we;
            rf_rd    <= wr_next.rd;
            rf_wdata <= wr_next.data;
            if (state == INIT) begin
                idx <= idx + 1'b1;
                if (idx == LAST_IDX) busy <= 1'b0;
            end
            if (a_ready)      last_grant <= GRANT_A;
            else if (b_ready) last_grant <= GRANT_B;
            if (contend && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural register-file model.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0]  a_rd = '0, b_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_we, busy;
    logic [3:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [15:0] conflict_cnt;
    logic [31:0] mem [16];
    int          checks = 0, passes = 0, fails = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.NREGS(16), .AW(4), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    // Register file: commits the registered write port on the next edge.
    always @(posedge clk) if (rf_we) mem[rf_rd] <= rf_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input logic we, input logic [3:0] rd, input logic [31:0] data);
        chk("rf_we", 32'(rf_we), 32'(we));
        chk("rf_rd", 32'(rf_rd), 32'(rd));
        chk("rf_wdata", rf_wdata, data);
    endtask

    // Drive one cycle at a negedge, check ready, then advance to the next negedge.
    task automatic cyc(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                       input logic bv, input logic [3:0] brd, input logic [31:0] bdat,
                       input logic ea, input logic eb);
        a_valid = av; a_rd = ard; a_data = adat;
        b_valid = bv; b_rd = brd; b_data = bdat;
        #1;
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expects rst_n low; checks reset values, releases reset and checks the clear.
    task automatic do_clear();
        a_valid = 1'b1; b_valid = 1'b1; a_rd = 4'd9; b_rd = 4'd10;
        a_data = '1; b_data = '1;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk_wr(1'b1, 4'(k - 1), 32'd0);
            chk("clr_busy", 32'(busy), (k < 16) ? 32'd1 : 32'd0);
            chk("clr_cnt", 32'(conflict_cnt), 32'd0);
            if (k < 16) begin
                chk("clr_a_ready", 32'(a_ready), 32'd0);
                chk("clr_b_ready", 32'(b_ready), 32'd0);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("post_clr_we", 32'(rf_we), 32'd0);
        chk("post_clr_r0", mem[0], 32'd0);
        chk("post_clr_r15", mem[15], 32'd0);
    endtask

    initial begin
        // Reset and clear, with both valids asserted during INIT.
        #13;
        do_clear();

        // Contention: A first (last_grant resets to B), then strict alternation.
        cyc(1, 4'd1, 32'd1, 1, 4'd5, 32'd5, 1, 0); chk_wr(1, 4'd1, 32'd1);
        cyc(1, 4'd2, 32'd2, 1, 4'd5, 32'd5, 0, 1); chk_wr(1, 4'd5, 32'd5);
        cyc(1, 4'd2, 32'd2, 1, 4'd6, 32'd6, 1, 0); chk_wr(1, 4'd2, 32'd2);
        cyc(1, 4'd3, 32'd3, 1, 4'd6, 32'd6, 0, 1); chk_wr(1, 4'd6, 32'd6);
        chk("cont_cnt", 32'(conflict_cnt), 32'd4);
        cyc(1, 4'd3, 32'd3, 0, 4'd0, 32'd0, 1, 0); chk_wr(1, 4'd3, 32'd3);
        cyc(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 0); chk_wr(0, 4'd3, 32'd3);
        chk("cont_cnt_hold", 32'(conflict_cnt), 32'd4);
        chk("mem_r1", mem[1], 32'd1);
        chk("mem_r5", mem[5], 32'd5);
        chk("mem_r2", mem[2], 32'd2);
        chk("mem_r6", mem[6], 32'd6);
        chk("mem_r3", mem[3], 32'd3);

        // Single requester A: r3 <= DEADBEEF, visible in the file one cycle later.
        cyc(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'd0, 1, 0);
        chk_wr(1, 4'd3, 32'hDEADBEEF);
        chk("single_mem_old", mem[3], 32'd3);
        cyc(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 0);
        chk_wr(0, 4'd3, 32'hDEADBEEF);
        chk("single_mem_new", mem[3], 32'hDEADBEEF);

        // Mid-operation reset while a write is on the port.
        cyc(0, 4'd0, 32'd0, 1, 4'd8, 32'h88, 0, 1);
        chk("mid_we_before", 32'(rf_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_we_async", 32'(rf_we), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_cnt", 32'(conflict_cnt), 32'd0);
        do_clear();
        chk("mid_r3_cleared", mem[3], 32'd0);

        // Same destination on a fresh reset: B's data lands last.
        #2 rst_n = 1'b0;
        do_clear();
        cyc(1, 4'd7, 32'h11, 1, 4'd7, 32'h22, 1, 0); chk_wr(1, 4'd7, 32'h11);
        cyc(0, 4'd0, 32'd0, 1, 4'd7, 32'h22, 0, 1); chk_wr(1, 4'd7, 32'h22);
        chk("same_mem_mid", mem[7], 32'h11);
        cyc(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 0);
        chk("same_mem_final", mem[7], 32'h22);
        chk("same_cnt", 32'(conflict_cnt), 32'd1);

        // Saturation: 70000 contended cycles must pin the counter at FFFF.
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", 32'(conflict_cnt), 32'h0000FFFF);
        chk("sat_one_ready", 32'(a_ready ^ b_ready), 32'd1);
        @(negedge clk);
        chk("sat_cnt_hold", 32'(conflict_cnt), 32'h0000FFFF);
        a_valid = 1'b0; b_valid = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

- Shares the register file's single synchronous write port between two writeback requesters: A (execute/ALU writeback) and B (load/memory unit).
- After every reset it runs a clear sequence that writes zero to every register before accepting any request.
- Drives the register file's `rd`, `write_data` and `reg_write` inputs from registered outputs. It also reports how often the two requesters collide.

## Interface

Parameters:
- `NREGS`, 16: number of registers to clear; must equal 2^`AW`.
- `AW`, 4: register index width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `a_valid`  in  1  requester A has a write pending.
- `a_rd`  in  AW  requester A destination register.
- `a_data`  in  DW  requester A write data.
- `a_ready`  out  1  A's request is accepted this cycle.
- `b_valid`, `b_rd`, `b_data`, `b_ready`: same as A's ports, for requester B.
- `rf_we`  out  1  write enable to the register file.
- `rf_rd`  out  AW  write index to the register file.
- `rf_wdata`  out  DW  write data to the register file.
- `busy`  out  1  clear sequence in progress.
- `conflict_cnt`  out  16  saturating count of cycles in which both requesters were valid.

## Operation

- **States:** INIT and RUN. Reset forces INIT with clear index `idx`=0.
- **INIT:**
  - Each cycle registers `rf_we`=1, `rf_rd`=`idx`, `rf_wdata`=0, then increments `idx`.
  - When `idx`==`NREGS`-1 is issued, the state moves to RUN.
  - `a_ready`=`b_ready`=0 throughout INIT; `valid` inputs are ignored and no conflicts are counted.
- **RUN arbitration (round-robin):**
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not granted most recently, and increment `conflict_cnt`, saturating at 16'hFFFF.
  - `last_grant` updates only on a grant. Its reset value is B, so A wins the first conflict.
- **Ready:** `a_ready`/`b_ready` are combinational, high only for the granted requester. At most one is high in any cycle.
- **Handshake:**
  - A transfer occurs when valid and ready are both high at a rising edge.
  - Requesters must hold valid, rd and data stable until accepted.
  - Valid must not depend on ready.
  - Ungranted requests wait; there is no drop and no reordering within a requester.
- **Write-port registers:**
  - On a transfer: `rf_we`<=1, `rf_rd`<=granted rd, `rf_wdata`<=granted data.
  - With no transfer in RUN: `rf_we`<=0; `rf_rd`/`rf_wdata` hold their previous values.
- **Same-rd collision:** both requesters are served in grant order, so the later grant's data is the final register value. Register 0 is not special-cased.
- **No back-pressure from the register file:** one write per cycle is always sustained.

## Timing

- **Reset values:** `rf_we`=0, `rf_rd`=0, `rf_wdata`=0, `a_ready`=0, `b_ready`=0, `busy`=1, `conflict_cnt`=0, `last_grant`=B, state=INIT, `idx`=0.
- **Clear sequence:**
  - Rising edges 1..`NREGS` after `rst_n` rises register clear writes to indices 0..`NREGS`-1; the register file commits each one on the following edge.
  - `busy` is registered and falls at edge `NREGS`.
  - `a_ready`/`b_ready` may first be high in the cycle after edge `NREGS`.
- **Write latency:** a request accepted at edge N appears on `rf_*` after edge N and is committed to the register file at edge N+1.
- **Readback:** a read of that register returns the new data from edge N+1 onward; this block provides no forwarding.
- **Throughput:** one accepted write per cycle. Under continuous contention, A and B each get every other cycle.
- **Reset mid-operation:**
  - Asserting `rst_n` low asynchronously returns all state to the reset values; in-flight `rf_we` drops immediately.
  - The clear sequence restarts from `idx`=0.
  - A request pending during reset must be re-presented and is served after INIT.

## Test plan

- **Reset and clear:** release `rst_n` -> `rf_we`=1 for exactly 16 cycles with `rf_rd`=0..15 and `rf_wdata`=0; `busy` falls at edge 16; `ready` stays low throughout.
- **Single requester:** after INIT, A writes r3=32'hDEADBEEF -> `a_ready`=1 that cycle; next cycle `rf_we`=1, `rf_rd`=3, `rf_wdata`=32'hDEADBEEF; register file r3 reads 32'hDEADBEEF one cycle later.
- **Contention:** A and B both continuously valid (A: r1=1, r2=2; B: r5=5, r6=6) -> grant order A, B, A, B; writes r1, r5, r2, r6 on consecutive cycles; `conflict_cnt`=4.
- **Same destination:** A r7=32'h11, B r7=32'h22 in the same cycle on a fresh reset -> A is written first, then B; final r7=32'h22.
- **Mid-operation reset:** drop `rst_n` while `rf_we`=1 in RUN -> `rf_we`=0 without waiting for a clock edge; after release, a full 16-cycle clear repeats; `conflict_cnt`=0.
- **Saturation:** hold both requesters valid for 70000 RUN cycles -> `conflict_cnt` stops at 16'hFFFF and does not wrap.
